// File: rtl/pair_bank_scheduler.sv
// Holds one reference for HOLD neighbour beats, queues matching {ref, nbr} pairs per lane, merges them round-robin.
// Optional macro PAIR_BANK_STATS_EN adds saturating pair_count / stall_count outputs.
module pair_bank_scheduler #(
  parameter int N_LANES = 4,
  parameter int REF_W   = 114,
  parameter int NBR_W   = 106,
  parameter int DEPTH   = 8,
  parameter int HOLD    = 16
) (
  input  logic                     fast_clk,
  input  logic                     reset,
  input  logic [REF_W-1:0]         ref_in,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  output logic [REF_W-1:0]         ref_hold_out,
  input  logic [N_LANES*NBR_W-1:0] nbr_in,
  input  logic [N_LANES-1:0]       nbr_match,
  input  logic                     nbr_valid,
  output logic                     nbr_ready,
  output logic [REF_W+NBR_W-1:0]   pair_out,
  output logic                     pair_valid,
  input  logic                     pair_ready,
  input  logic                     upstream_done,
`ifdef PAIR_BANK_STATS_EN
  output logic [31:0]              pair_count,
  output logic [31:0]              stall_count,
`endif
  output logic                     done
);

  localparam int PW   = REF_W + NBR_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(HOLD + 1);
  localparam int RW   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [REF_W-1:0] r_ref_hold;
  logic [CW-1:0]    r_beat_cnt;
  logic [PW-1:0]    r_mem    [N_LANES][DEPTH];
  logic [AW-1:0]    r_wr_ptr [N_LANES];
  logic [AW-1:0]    r_rd_ptr [N_LANES];
  logic [CNTW-1:0]  r_cnt    [N_LANES];
  logic [RW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_pair_out;
  logic             r_pair_valid;
  logic             r_done;

  logic               w_full_any;
  logic [N_LANES-1:0] w_nonempty;
  logic [N_LANES-1:0] w_push;
  logic [N_LANES-1:0] w_pop;
  logic               w_nbr_acc;
  logic               w_grant_vld;
  logic [RW-1:0]      w_grant_idx;
  logic [RW-1:0]      w_scan;
  logic               w_load;

  assign ref_ready    = (r_state == S_IDLE);
  assign nbr_ready    = (r_state == S_RUN) & ~w_full_any;
  assign ref_hold_out = r_ref_hold;
  assign pair_out     = r_pair_out;
  assign pair_valid   = r_pair_valid;
  assign done         = r_done;

  assign w_nbr_acc = nbr_valid & nbr_ready;
  assign w_push    = nbr_match & {N_LANES{w_nbr_acc}};
  assign w_load    = ~r_pair_valid | pair_ready;

  // Full is judged on registered counts only, so a same-cycle pop never frees a slot.
  always_comb begin
    w_full_any = 1'b0;
    w_nonempty = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (r_cnt[i] == CNTW'(DEPTH)) w_full_any = 1'b1;
      w_nonempty[i] = (r_cnt[i] != '0);
    end
  end

  // Scan downwards so the lane closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      w_scan = RW'((int'(r_rr_ptr) + k) % N_LANES);
      if (w_nonempty[w_scan]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_LANES; i++)
      w_pop[i] = w_grant_vld & w_load & (w_grant_idx == RW'(i));
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ref_hold <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ref_valid) begin
            r_ref_hold <= ref_in;
            r_beat_cnt <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_nbr_acc) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (r_beat_cnt == CW'(HOLD - 1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fast_clk) begin
    for (int i = 0; i < N_LANES; i++)
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= {r_ref_hold, nbr_in[i*NBR_W +: NBR_W]};
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNTW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNTW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      r_pair_out   <= '0;
      r_pair_valid <= 1'b0;
      r_rr_ptr     <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_grant_vld && w_load) begin
        r_pair_out   <= r_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
        r_pair_valid <= 1'b1;
        r_rr_ptr     <= (w_grant_idx == RW'(N_LANES - 1)) ? '0 : w_grant_idx + RW'(1);
      end else if (pair_ready) begin
        r_pair_valid <= 1'b0;
      end
      r_done <= upstream_done & (r_state == S_IDLE) & ~(|w_nonempty) & ~r_pair_valid;
    end
  end

`ifdef PAIR_BANK_STATS_EN
  logic [31:0] r_pair_count;
  logic [31:0] r_stall_count;

  assign pair_count  = r_pair_count;
  assign stall_count = r_stall_count;

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      r_pair_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_pair_valid && pair_ready && r_pair_count != 32'hFFFF_FFFF)
        r_pair_count <= r_pair_count + 32'd1;
      if (r_state == S_RUN && nbr_valid && !nbr_ready && r_stall_count != 32'hFFFF_FFFF)
        r_stall_count <= r_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pair_bank_scheduler.sv
// Scoreboarded bench: per-lane expected pair queues filled at beat acceptance, drained by an output monitor.
module tb_pair_bank_scheduler;
  localparam int N_LANES = 4;
  localparam int REF_W   = 114;
  localparam int NBR_W   = 106;
  localparam int DEPTH   = 8;
  localparam int HOLD    = 16;
  localparam int PW      = REF_W + NBR_W;

  logic                     fast_clk = 1'b0;
  logic                     reset = 1'b1;
  logic [REF_W-1:0]         ref_in = '0;
  logic                     ref_valid = 1'b0;
  logic                     ref_ready;
  logic [REF_W-1:0]         ref_hold_out;
  logic [N_LANES*NBR_W-1:0] nbr_in = '0;
  logic [N_LANES-1:0]       nbr_match = '0;
  logic                     nbr_valid = 1'b0;
  logic                     nbr_ready;
  logic [PW-1:0]            pair_out;
  logic                     pair_valid;
  logic                     pair_ready = 1'b1;
  logic                     upstream_done = 1'b0;
  logic                     done;
`ifdef PAIR_BANK_STATS_EN
  logic [31:0]              pair_count;
  logic [31:0]              stall_count;
`endif

  pair_bank_scheduler #(.N_LANES(N_LANES), .REF_W(REF_W), .NBR_W(NBR_W), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .fast_clk(fast_clk), .reset(reset),
    .ref_in(ref_in), .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_hold_out(ref_hold_out),
    .nbr_in(nbr_in), .nbr_match(nbr_match), .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
    .pair_out(pair_out), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .upstream_done(upstream_done),
`ifdef PAIR_BANK_STATS_EN
    .pair_count(pair_count), .stall_count(stall_count),
`endif
    .done(done)
  );

  always #5 fast_clk = ~fast_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0]    exp_q [N_LANES][$];
  int               lane_log[$];
  int               cyc = 0;
  int               last_hs = -1;
  int               done_rise = -1;
  int               n_pairs_run = 0;
  bit               done_prev = 1'b0;
  int               pr_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int               acc_beats = 0;
  logic [REF_W-1:0] cur_ref = '0;
  logic [PW-1:0]    held_pair;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no handshake, required one", name);
  endtask

  function automatic int q_total();
    int s = 0;
    for (int i = 0; i < N_LANES; i++) s += exp_q[i].size();
    return s;
  endfunction

  function automatic logic [REF_W-1:0] rnd_ref();
    logic [127:0] t;
    for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
    return t[REF_W-1:0];
  endfunction

  // Lane id rides in the neighbour LSBs so the monitor can pick the right queue.
  function automatic logic [NBR_W-1:0] rnd_nbr(input int lane);
    logic [127:0] t;
    for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
    t[3:0] = 4'(lane);
    return t[NBR_W-1:0];
  endfunction

  always @(posedge fast_clk) begin
    #2;
    case (pr_mode)
      0:       pair_ready = 1'b1;
      1:       pair_ready = 1'($urandom_range(0, 1));
      default: pair_ready = 1'b0;
    endcase
  end

  always @(negedge fast_clk) begin
    int lane;
    cyc++;
    if (reset) begin
      n_pairs_run = 0;
    end else begin
      if (pair_valid && pair_ready) begin
        lane = int'(pair_out[3:0]);
        n_pairs_run++;
        last_hs = cyc;
        lane_log.push_back(lane);
        if (lane >= N_LANES || exp_q[lane].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pair: got %h, required no pair", pair_out);
        end else begin
          chkw("pair_data", pair_out, exp_q[lane].pop_front());
        end
      end
      if (done && !done_prev) done_rise = cyc;
    end
    done_prev = done;
  end

  task automatic send_ref(input logic [REF_W-1:0] r);
    ref_in    = r;
    ref_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge fast_clk);
      if (ref_ready) begin
        cur_ref = r;
        @(posedge fast_clk); #1;
        ref_valid = 1'b0;
        return;
      end
      @(posedge fast_clk); #1;
    end
    ref_valid = 1'b0;
    timeout_fail("ref_accept");
  endtask

  task automatic send_one_beat(input logic [N_LANES-1:0] m);
    logic [NBR_W-1:0] w [N_LANES];
    for (int i = 0; i < N_LANES; i++) begin
      w[i] = rnd_nbr(i);
      nbr_in[i*NBR_W +: NBR_W] = w[i];
    end
    nbr_match = m;
    nbr_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge fast_clk);
      if (nbr_ready) begin
        for (int i = 0; i < N_LANES; i++)
          if (m[i]) exp_q[i].push_back({cur_ref, w[i]});
        acc_beats++;
        @(posedge fast_clk); #1;
        nbr_valid = 1'b0;
        return;
      end
      @(posedge fast_clk); #1;
    end
    nbr_valid = 1'b0;
    timeout_fail("nbr_accept");
  endtask

  // kind 0: fixed match, 1: random match, 2: four 0011 beats then empty-match beats.
  task automatic send_beats(input int kind, input logic [N_LANES-1:0] m, input bit gaps);
    logic [N_LANES-1:0] mm;
    for (int b = 0; b < HOLD; b++) begin
      if (kind == 0)      mm = m;
      else if (kind == 1) mm = N_LANES'($urandom_range(0, (1 << N_LANES) - 1));
      else                mm = (b < 4) ? N_LANES'(3) : '0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge fast_clk); #1;
      end
      send_one_beat(mm);
      if (b == 0) begin
        chkw("ref_hold_out", {ref_hold_out, NBR_W'(0)}, {cur_ref, NBR_W'(0)});
        chk("ref_ready_run", 32'(ref_ready), 0);
      end
    end
    @(negedge fast_clk);
    chk("ref_ready_after_hold", 32'(ref_ready), 1);
    chk("nbr_ready_idle", 32'(nbr_ready), 0);
    @(posedge fast_clk); #1;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000; t++) begin
      @(negedge fast_clk);
      if (q_total() == 0 && !pair_valid) begin
        @(posedge fast_clk); #1;
        return;
      end
    end
    timeout_fail("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    chk("rst_ref_ready", 32'(ref_ready), 1);
    chk("rst_nbr_ready", 32'(nbr_ready), 0);
    chk("rst_pair_valid", 32'(pair_valid), 0);
    chk("rst_done", 32'(done), 0);
    chkw("rst_pair_out", pair_out, '0);
    chkw("rst_ref_hold", {ref_hold_out, NBR_W'(0)}, '0);
    @(posedge fast_clk); #1;
    reset = 1'b0;
    @(posedge fast_clk); #1;

    // All lanes match, consumer always ready: strict 0,1,2,3 rotation.
    lane_log.delete();
    send_ref(rnd_ref());
    send_beats(0, N_LANES'(4'hF), 1'b0);
    wait_drain();
    chk("p1_pair_total", lane_log.size(), 64);
    for (int i = 0; i < lane_log.size() && i < 64; i++) chk("p1_lane_order", lane_log[i], i % 4);

    // Match 1010: only lanes 1 and 3, alternating.
    lane_log.delete();
    send_ref(rnd_ref());
    send_beats(0, N_LANES'(4'b1010), 1'b0);
    wait_drain();
    chk("p2_pair_total", lane_log.size(), 32);
    for (int i = 0; i < lane_log.size() && i < 32; i++) chk("p2_lane_alt", lane_log[i], (i % 2 == 0) ? 1 : 3);

    // Consumer stalled for 40 cycles: exactly 8 beats fit, output held stable.
    pr_mode = 2;
    @(posedge fast_clk); #1;
    send_ref(rnd_ref());
    acc_beats = 0;
    fork
      send_beats(0, N_LANES'(4'hF), 1'b0);
      begin
        repeat (5) @(negedge fast_clk);
        chk("p3_pair_valid_held", 32'(pair_valid), 1);
        held_pair = pair_out;
        repeat (35) begin
          @(negedge fast_clk);
          chkw("p3_pair_stable", pair_out, held_pair);
        end
        chk("p3_beats_before_full", acc_beats, 8);
        chk("p3_nbr_ready_low", 32'(nbr_ready), 0);
        @(posedge fast_clk); #1;
        pr_mode = 0;
      end
    join
    wait_drain();

    // Back-to-back references, random match, random gaps and backpressure.
    pr_mode = 1;
    for (int r = 0; r < 4; r++) begin
      send_ref(rnd_ref());
      send_beats(1, '0, 1'b1);
    end
    wait_drain();
    chk("p4_queues_empty", q_total(), 0);

    // Reset mid-RUN with five entries queued.
    pr_mode = 2;
    @(posedge fast_clk); #1;
    send_ref(rnd_ref());
    send_one_beat(N_LANES'(4'b0111));
    send_one_beat(N_LANES'(4'b0011));
    upstream_done = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < N_LANES; i++) exp_q[i].delete();
    @(posedge fast_clk); #1;
    reset = 1'b0;
    @(negedge fast_clk);
    chk("p5_pair_valid", 32'(pair_valid), 0);
    chk("p5_ref_ready", 32'(ref_ready), 1);
    chk("p5_done", 32'(done), 0);
    chk("p5_nbr_ready", 32'(nbr_ready), 0);
    chkw("p5_pair_out", pair_out, '0);
    @(posedge fast_clk); #1;
    pr_mode = 0;
    repeat (20) @(posedge fast_clk);
    #1;
    chk("p5_done_idle", 32'(done), 1);
    upstream_done = 1'b0;
    repeat (2) @(posedge fast_clk);
    #1;
    chk("p5_done_falls", 32'(done), 0);

    // done rises one cycle after the final pair handshake.
    pr_mode = 2;
    @(posedge fast_clk); #1;
    send_ref(rnd_ref());
    send_beats(2, '0, 1'b0);
    upstream_done = 1'b1;
    @(negedge fast_clk);
    chk("p6_done_pending", 32'(done), 0);
    @(posedge fast_clk); #1;
    pr_mode = 1;
    begin
      bit seen = 1'b0;
      for (int t = 0; t < 3000 && !seen; t++) begin
        @(negedge fast_clk);
        #1;
        if (done) seen = 1'b1;
      end
      if (!seen) timeout_fail("p6_done_rise");
      else begin
        chk("p6_done_latency", done_rise - last_hs, 2);
        chk("p6_queues_empty", q_total(), 0);
`ifdef PAIR_BANK_STATS_EN
        chk("p6_pair_count", pair_count, n_pairs_run);
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
